// File: rtl/round_pipe.sv
// Two-stage pipelined fixed-point to integer rounder with valid/ready handshake.
// Define ROUND_SAT_EN to clamp overflowing results to max positive instead of wrapping.
module round_pipe #(
   parameter int unsigned DW = 8,
   parameter int unsigned FW = 4,
   parameter int unsigned CW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [DW-1:0]      a,
   input  logic [1:0]         mode,
   output logic               z_valid,
   input  logic               z_ready,
   output logic [DW-FW-1:0]   z,
   output logic               z_inexact,
   output logic               z_ovf,
   input  logic               clr,
   output logic [CW-1:0]      inex_cnt
);

   localparam int unsigned IW = DW - FW;
   localparam logic [IW-1:0] MAX_POS = {1'b0, {(IW-1){1'b1}}};
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      RNE = 2'd0,
      RTZ = 2'd1,
      RDN = 2'd2,
      RUP = 2'd3
   } mode_e;

   logic [IW-1:0] a_int;
   logic [FW-1:0] frac;
   logic          half;
   logic          tail;
   logic          inex_c;
   logic          r_c;
   logic          ovf_c;

   logic          s1_valid;
   logic [IW-1:0] s1_int;
   logic          s1_r;
   logic          s1_inex;
   logic          s1_ovf;

   logic          s2_load;
   logic [IW-1:0] sum_c;
   logic [IW-1:0] z_next_c;
   logic          z_fire;

   // Operand split and per-mode round-up decision
   always_comb begin
      a_int  = a[DW-1:FW];
      frac   = a[FW-1:0];
      half   = frac[FW-1];
      tail   = |frac[FW-2:0];
      inex_c = |frac;
      r_c    = 1'b0;
      case (mode_e'(mode))
         RNE:     r_c = half & (tail | a_int[0]);
         RTZ:     r_c = a[DW-1] & inex_c;
         RDN:     r_c = 1'b0;
         RUP:     r_c = inex_c;
         default: r_c = 1'b0;
      endcase
      ovf_c = r_c & (a_int == MAX_POS);
   end

   // Stage 2 advances when empty or drained; stage 1 advances with it
   assign s2_load = ~z_valid | z_ready;
   assign a_ready = ~s1_valid | s2_load;
   assign z_fire  = z_valid & z_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_int   <= '0;
         s1_r     <= 1'b0;
         s1_inex  <= 1'b0;
         s1_ovf   <= 1'b0;
      end else if (a_ready) begin
         s1_valid <= a_valid;
         if (a_valid) begin
            s1_int  <= a_int;
            s1_r    <= r_c;
            s1_inex <= inex_c;
            s1_ovf  <= ovf_c;
         end
      end
   end

   // Increment wraps modulo 2^IW, which already yields most-negative on overflow
   always_comb begin
      sum_c    = s1_int + IW'(s1_r);
      z_next_c = sum_c;
`ifdef ROUND_SAT_EN
      if (s1_ovf) begin
         z_next_c = MAX_POS;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_valid   <= 1'b0;
         z         <= '0;
         z_inexact <= 1'b0;
         z_ovf     <= 1'b0;
      end else if (s2_load) begin
         z_valid <= s1_valid;
         if (s1_valid) begin
            z         <= z_next_c;
            z_inexact <= s1_inex;
            z_ovf     <= s1_ovf;
         end
      end
   end

   // Saturating inexact counter; clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inex_cnt <= '0;
      end else if (clr) begin
         inex_cnt <= '0;
      end else if (z_fire && z_inexact && (inex_cnt != CNT_MAX)) begin
         inex_cnt <= inex_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_round_pipe.sv
// Directed bench for round_pipe (DW=8, FW=4, CW=8); honours ROUND_SAT_EN.
module tb_round_pipe;

   localparam int unsigned DW = 8;
   localparam int unsigned FW = 4;
   localparam int unsigned CW = 8;
   localparam int NV = 23;

`ifdef ROUND_SAT_EN
   localparam logic [3:0] OVZ = 4'h7;
`else
   localparam logic [3:0] OVZ = 4'h8;
`endif

   typedef struct {
      logic [7:0] a;
      logic [1:0] mode;
      logic [3:0] z;
      logic       inex;
      logic       ovf;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          a_valid;
   logic          a_ready;
   logic [DW-1:0] a;
   logic [1:0]    mode;
   logic          z_valid;
   logic          z_ready;
   logic [DW-FW-1:0] z;
   logic          z_inexact;
   logic          z_ovf;
   logic          clr;
   logic [CW-1:0] inex_cnt;

   int n_chk;
   int n_fail;
   int exp_cnt;
   vec_t vecs [NV];

   round_pipe #(.DW(DW), .FW(FW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a(a), .mode(mode),
      .z_valid(z_valid), .z_ready(z_ready), .z(z),
      .z_inexact(z_inexact), .z_ovf(z_ovf),
      .clr(clr), .inex_cnt(inex_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [7:0] av, input logic [1:0] m,
                                input logic [3:0] zv, input logic ix, input logic ov);
      vec_t v;
      v.a = av; v.mode = m; v.z = zv; v.inex = ix; v.ovf = ov;
      return v;
   endfunction

   function automatic int sat_add(input int c, input int n);
      return (c + n > 255) ? 255 : c + n;
   endfunction

   // One transaction with z_ready high: checks latency and the result fields
   task automatic send_one(input int i);
      int lat;
      @(negedge clk);
      a = vecs[i].a; mode = vecs[i].mode; a_valid = 1'b1; z_ready = 1'b1;
      chk($sformatf("a_ready[%0d]", i), int'(a_ready), 1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0; a = 8'h00; mode = 2'd0;
      lat = 1;
      while (!z_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("latency[%0d]", i), lat, 2);
      chk($sformatf("z[%0d] a=%0h m=%0d", i, vecs[i].a, vecs[i].mode), int'(z), int'(vecs[i].z));
      chk($sformatf("inexact[%0d]", i), int'(z_inexact), int'(vecs[i].inex));
      chk($sformatf("ovf[%0d]", i), int'(z_ovf), int'(vecs[i].ovf));
      if (z_valid && vecs[i].inex) exp_cnt = sat_add(exp_cnt, 1);
      @(posedge clk);
   endtask

   initial begin
      logic [3:0] exp_q [3];
      int got;
      n_chk = 0; n_fail = 0; exp_cnt = 0;
      rst = 1'b1; a_valid = 1'b0; a = '0; mode = '0; z_ready = 1'b0; clr = 1'b0;

      vecs[0]  = mkv(8'h28, 2'd0, 4'h2, 1'b1, 1'b0);
      vecs[1]  = mkv(8'h38, 2'd0, 4'h4, 1'b1, 1'b0);
      vecs[2]  = mkv(8'hD8, 2'd0, 4'hE, 1'b1, 1'b0);
      vecs[3]  = mkv(8'h21, 2'd3, 4'h3, 1'b1, 1'b0);
      vecs[4]  = mkv(8'h21, 2'd2, 4'h2, 1'b1, 1'b0);
      vecs[5]  = mkv(8'hE1, 2'd1, 4'hF, 1'b1, 1'b0);
      vecs[6]  = mkv(8'hE1, 2'd2, 4'hE, 1'b1, 1'b0);
      vecs[7]  = mkv(8'h30, 2'd0, 4'h3, 1'b0, 1'b0);
      vecs[8]  = mkv(8'h30, 2'd1, 4'h3, 1'b0, 1'b0);
      vecs[9]  = mkv(8'h30, 2'd2, 4'h3, 1'b0, 1'b0);
      vecs[10] = mkv(8'h30, 2'd3, 4'h3, 1'b0, 1'b0);
      vecs[11] = mkv(8'h7C, 2'd0, OVZ,  1'b1, 1'b1);
      vecs[12] = mkv(8'h7F, 2'd3, OVZ,  1'b1, 1'b1);
      vecs[13] = mkv(8'h7F, 2'd1, 4'h7, 1'b1, 1'b0);
      vecs[14] = mkv(8'h19, 2'd0, 4'h2, 1'b1, 1'b0);
      vecs[15] = mkv(8'h87, 2'd0, 4'h8, 1'b1, 1'b0);
      vecs[16] = mkv(8'h81, 2'd3, 4'h9, 1'b1, 1'b0);
      vecs[17] = mkv(8'h8F, 2'd2, 4'h8, 1'b1, 1'b0);
      vecs[18] = mkv(8'h8F, 2'd1, 4'h9, 1'b1, 1'b0);
      vecs[19] = mkv(8'hF8, 2'd0, 4'h0, 1'b1, 1'b0);
      vecs[20] = mkv(8'h78, 2'd0, OVZ,  1'b1, 1'b1);
      vecs[21] = mkv(8'h70, 2'd3, 4'h7, 1'b0, 1'b0);
      vecs[22] = mkv(8'h7F, 2'd2, 4'h7, 1'b1, 1'b0);

      #12;
      chk("reset z_valid", int'(z_valid), 0);
      chk("reset a_ready", int'(a_ready), 1);
      chk("reset z", int'(z), 0);
      chk("reset inex_cnt", int'(inex_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) send_one(i);
      @(negedge clk);
      chk("inex_cnt after table", int'(inex_cnt), exp_cnt);

      // Back-pressure: two accepted, then a_ready drops and z holds
      exp_q[0] = 4'h2; exp_q[1] = 4'h3; exp_q[2] = 4'h3;
      z_ready = 1'b0; a = 8'h28; mode = 2'd0; a_valid = 1'b1;
      chk("stall a_ready A", int'(a_ready), 1);
      @(posedge clk); @(negedge clk);
      a = 8'h21; mode = 2'd3;
      chk("stall a_ready B", int'(a_ready), 1);
      @(posedge clk); @(negedge clk);
      a = 8'h30; mode = 2'd1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stall a_ready low %0d", k), int'(a_ready), 0);
         chk($sformatf("stall z_valid %0d", k), int'(z_valid), 1);
         chk($sformatf("stall z held %0d", k), int'(z), 2);
         @(posedge clk); @(negedge clk);
      end
      z_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 8 && got < 3; k++) begin
         if (z_valid) begin
            chk($sformatf("drain order %0d", got), int'(z), int'(exp_q[got]));
            got++;
         end
         @(posedge clk); @(negedge clk);
         a_valid = 1'b0;
      end
      chk("drain count", got, 3);
      chk("no duplicate", int'(z_valid), 0);
      exp_cnt = sat_add(exp_cnt, 2);
      chk("inex_cnt after drain", int'(inex_cnt), exp_cnt);

      // Saturation: 300 inexact results streamed back to back
      a = 8'h21; mode = 2'd2; a_valid = 1'b1; z_ready = 1'b1;
      repeat (300) @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp_cnt = sat_add(exp_cnt, 300);
      chk("inex_cnt saturated", int'(inex_cnt), exp_cnt);

      // clr beats a same-cycle increment
      a = 8'h21; a_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      a_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("clr setup z_valid", int'(z_valid & z_inexact), 1);
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0;
      chk("inex_cnt after clr", int'(inex_cnt), 0);

      // Asynchronous reset with both stages full
      z_ready = 1'b0; a = 8'h38; mode = 2'd0; a_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      a_valid = 1'b0;
      chk("full before reset", int'(z_valid & ~a_ready), 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst z_valid", int'(z_valid), 0);
      chk("async rst a_ready", int'(a_ready), 1);
      chk("async rst z", int'(z), 0);
      @(negedge clk);
      rst = 1'b0;
      z_ready = 1'b1;
      send_one(2);
      send_one(11);
      @(negedge clk);
      chk("post-reset no stale", int'(z_valid), 0);
      chk("post-reset inex_cnt", int'(inex_cnt), exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
